// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable integer clock divider, clk_out = clk / N.
// N is taken from a pending register and applied only at period boundaries, so
// clk_out never produces runt pulses. en parks the divider at the next boundary.
// A one-clk tick marks the start of every output period in the clk domain.
// Optional feature macro: CLKDIV_ODD_EN adds a negedge retiming flop so that odd N
// also runs at exactly 50% duty. Without it, odd N is high H clks and low H+1 clks.
module clkdiv_prog #(
  parameter int CNT_W    = 8,
  parameter int DIV_INIT = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_err,
  output logic             busy,
  output logic [CNT_W-1:0] active_div,
  output logic             running,
  output logic             tick,
  output logic             clk_out
);

  typedef enum logic {
    ST_PARK = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_active_div;
  logic [CNT_W-1:0] r_pending;
  logic             r_busy;
  logic             r_running;
  logic             r_tick;
  logic             r_div_err;
  logic             r_pos_q;

  logic [CNT_W-1:0] w_half;
  logic             w_wrap;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_clk_out;

  // High phase length and the last count of the current period.
  assign w_half     = r_active_div >> 1;
  assign w_wrap     = (r_cnt == (r_active_div - CNT_W'(1)));
  assign w_load_ok  = div_load & (div_val >= CNT_W'(2));
  assign w_load_bad = div_load & (div_val <  CNT_W'(2));

  // Divider FSM: period counter, divisor reload, park control and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_PARK;
      r_cnt        <= '0;
      r_active_div <= DIV_RST;
      r_pending    <= DIV_RST;
      r_busy       <= 1'b0;
      r_running    <= 1'b0;
      r_tick       <= 1'b0;
      r_div_err    <= 1'b0;
      r_pos_q      <= 1'b0;
    end else begin
      // Strobes and the output phase are derived from the state before this edge,
      // so tick and the clk_out rising edge appear one clk after cnt==0.
      r_tick    <= (r_state == ST_RUN) && (r_cnt == '0);
      r_pos_q   <= (r_state == ST_RUN) && (r_cnt < w_half);
      r_div_err <= w_load_bad;

      case (r_state)
        ST_PARK: begin
          r_cnt <= '0;
          // Output is already low while parked, so a pending divisor can go live now.
          if (r_busy) begin
            r_active_div <= r_pending;
            r_busy       <= 1'b0;
          end
          if (en) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_wrap) begin
            r_cnt <= '0;
            // clk_out is low on the wrap edge, so the divisor swap cannot cut a pulse.
            if (r_busy) begin
              r_active_div <= r_pending;
              r_busy       <= 1'b0;
            end
            if (!en) begin
              r_state   <= ST_PARK;
              r_running <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= ST_PARK;
          r_running <= 1'b0;
          r_cnt     <= '0;
        end
      endcase

      // A new request wins over the clear above: a load landing on a boundary
      // becomes the next pending value while the older one is being applied.
      if (w_load_ok) begin
        r_pending <= div_val;
        r_busy    <= 1'b1;
      end
    end
  end

`ifdef CLKDIV_ODD_EN
  logic r_neg_q;

  // Half-cycle extension of the high phase, only for odd divisors.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
    end else begin
      r_neg_q <= r_pos_q & r_active_div[0];
    end
  end

  assign w_clk_out = r_pos_q | r_neg_q;
`else
  assign w_clk_out = r_pos_q;
`endif

  assign div_err    = r_div_err;
  assign busy       = r_busy;
  assign active_div = r_active_div;
  assign running    = r_running;
  assign tick       = r_tick;
  assign clk_out    = w_clk_out;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Self-checking bench for clkdiv_prog (CNT_W=8, DIV_INIT=25).
// Expected period records are queued when stimulus is driven and popped as each
// output period completes.
module tb_clkdiv_prog;

`ifdef CLKDIV_ODD_EN
  localparam bit ODD_EN = 1'b1;
`else
  localparam bit ODD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] hi;
    logic        bsy;
  } per_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_err;
  logic       busy;
  logic [7:0] active_div;
  logic       running;
  logic       tick;
  logic       clk_out;

  int   checks   = 0;
  int   failures = 0;
  per_t exp_q[$];

  clkdiv_prog #(.CNT_W(8), .DIV_INIT(25)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_val   (div_val),
    .div_load  (div_load),
    .div_err   (div_err),
    .busy      (busy),
    .active_div(active_div),
    .running   (running),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected record: period length N, high half-cycles, busy seen just before the wrap.
  function automatic per_t mk(input int n, input bit b);
    per_t p;
    p.len = 16'(n);
    p.hi  = ((n % 2) == 1 && !ODD_EN) ? 16'(n - 1) : 16'(n);
    p.bsy = b;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 600);
  endtask

  // Starts just after a tick edge; runs to the next tick, optionally issuing loads
  // at cycle indices ld_a / ld_b of the period.
  task automatic measure_period(input int ld_a, input logic [7:0] va,
                                input int ld_b, input logic [7:0] vb,
                                output per_t got);
    int  len;
    int  hi;
    bit  b_last;
    bit  b_pre;
    bit  done;
    len = 0; hi = 0; b_last = 1'b0; b_pre = 1'b0; done = 1'b0;
    while (!done) begin
      if (clk_out === 1'b1) hi++;
      b_pre  = b_last;
      b_last = (busy === 1'b1);
      if (len == ld_a) begin
        div_load = 1'b1; div_val = va;
      end else if (len == ld_b) begin
        div_load = 1'b1; div_val = vb;
      end else begin
        div_load = 1'b0;
      end
      @(negedge clk);
      #1;
      if (clk_out === 1'b1) hi++;
      @(posedge clk);
      #1;
      len++;
      if (tick === 1'b1) done = 1'b1;
      else if (len >= 600) done = 1'b1;
    end
    div_load = 1'b0;
    got.len = 16'(len);
    got.hi  = 16'(hi);
    got.bsy = b_pre;
  endtask

  task automatic test_reset();
    per_t got, e;
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_val = 8'd0;
    #12;
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL rst_clk_out got=%b exp=0", clk_out); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL rst_tick got=%b exp=0", tick); end
    checks++; if (div_err !== 1'b0) begin failures++; $display("FAIL rst_div_err got=%b exp=0", div_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL rst_running got=%b exp=0", running); end
    checks++; if (active_div !== 8'd25) begin failures++; $display("FAIL rst_active_div got=%0d exp=25", active_div); end
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running got=%b exp=1", running); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL start_tick_early got=%b exp=0", tick); end
    step();
    checks++; if (tick !== 1'b1) begin failures++; $display("FAIL start_tick got=%b exp=1", tick); end
    checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL start_clk_out got=%b exp=1", clk_out); end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(25, 1'b0));
      measure_period(-1, 8'd0, -1, 8'd0, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL period25_%0d got len=%0d hi=%0d bsy=%0d exp len=%0d hi=%0d bsy=%0d",
                 i, got.len, got.hi, got.bsy, e.len, e.hi, e.bsy);
      end
    end
  endtask

  task automatic test_reload();
    per_t got, e;
    exp_q.push_back(mk(25, 1'b1));
    exp_q.push_back(mk(4, 1'b0));
    exp_q.push_back(mk(4, 1'b0));
    measure_period(3, 8'd4, -1, 8'd0, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL reload_old got len=%0d hi=%0d bsy=%0d exp len=%0d hi=%0d bsy=%0d",
               got.len, got.hi, got.bsy, e.len, e.hi, e.bsy);
    end
    checks++; if (active_div !== 8'd4) begin failures++; $display("FAIL reload_active got=%0d exp=4", active_div); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reload_busy_clr got=%b exp=0", busy); end
    for (int i = 0; i < 2; i++) begin
      measure_period(-1, 8'd0, -1, 8'd0, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reload_new_%0d got len=%0d hi=%0d bsy=%0d exp len=%0d hi=%0d bsy=%0d",
                 i, got.len, got.hi, got.bsy, e.len, e.hi, e.bsy);
      end
    end
  endtask

  task automatic test_back_to_back();
    per_t got, e;
    exp_q.push_back(mk(4, 1'b1));
    measure_period(0, 8'd6, 1, 8'd10, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL b2b_period got len=%0d hi=%0d bsy=%0d exp len=%0d hi=%0d bsy=%0d",
               got.len, got.hi, got.bsy, e.len, e.hi, e.bsy);
    end
    checks++; if (active_div !== 8'd10) begin failures++; $display("FAIL b2b_active got=%0d exp=10", active_div); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", busy); end
  endtask

  task automatic test_load_at_wrap();
    per_t got, e;
    exp_q.push_back(mk(10, 1'b1));
    exp_q.push_back(mk(6, 1'b1));
    exp_q.push_back(mk(8, 1'b0));
    // 6 loads early; 8 lands exactly on the wrap edge of this 10-clk period.
    measure_period(2, 8'd6, 8, 8'd8, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL wrapld_10 got len=%0d hi=%0d bsy=%0d exp len=%0d hi=%0d bsy=%0d",
               got.len, got.hi, got.bsy, e.len, e.hi, e.bsy);
    end
    checks++; if (active_div !== 8'd6) begin failures++; $display("FAIL wrapld_active6 got=%0d exp=6", active_div); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wrapld_busy_held got=%b exp=1", busy); end
    measure_period(-1, 8'd0, -1, 8'd0, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL wrapld_6 got len=%0d hi=%0d bsy=%0d exp len=%0d hi=%0d bsy=%0d",
               got.len, got.hi, got.bsy, e.len, e.hi, e.bsy);
    end
    checks++; if (active_div !== 8'd8) begin failures++; $display("FAIL wrapld_active8 got=%0d exp=8", active_div); end
    measure_period(-1, 8'd0, -1, 8'd0, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL wrapld_8 got len=%0d hi=%0d bsy=%0d exp len=%0d hi=%0d bsy=%0d",
               got.len, got.hi, got.bsy, e.len, e.hi, e.bsy);
    end
  endtask

  task automatic test_div_err();
    int n;
    logic [7:0] bad_vals [2];
    bad_vals[0] = 8'd1;
    bad_vals[1] = 8'd0;
    for (int i = 0; i < 2; i++) begin
      div_load = 1'b1; div_val = bad_vals[i];
      step();
      checks++; if (div_err !== 1'b1) begin failures++; $display("FAIL err_pulse_%0d got=%b exp=1", i, div_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL err_busy_%0d got=%b exp=0", i, busy); end
      checks++; if (active_div !== 8'd8) begin failures++; $display("FAIL err_active_%0d got=%0d exp=8", i, active_div); end
    end
    div_load = 1'b0; div_val = 8'd0;
    step();
    checks++; if (div_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", div_err); end
    wait_tick(n);
    checks++; if (n !== 5) begin failures++; $display("FAIL err_resync got=%0d exp=5", n); end
  endtask

  task automatic test_park();
    per_t got, e;
    bit   quiet;
    step();
    step();
    en = 1'b0;
    repeat (4) step();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL park_no_truncate got=%b exp=1", running); end
    step();
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL park_running got=%b exp=0", running); end
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (clk_out !== 1'b0 || tick !== 1'b0) quiet = 1'b0;
      @(negedge clk);
      #1;
      if (clk_out !== 1'b0) quiet = 1'b0;
      step();
    end
    checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL park_quiet got=%b exp=1", quiet); end
    en = 1'b1;
    step();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL unpark_running got=%b exp=1", running); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL unpark_tick_early got=%b exp=0", tick); end
    step();
    checks++; if (tick !== 1'b1) begin failures++; $display("FAIL unpark_tick got=%b exp=1", tick); end
    exp_q.push_back(mk(8, 1'b0));
    measure_period(-1, 8'd0, -1, 8'd0, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL unpark_period got len=%0d hi=%0d bsy=%0d exp len=%0d hi=%0d bsy=%0d",
               got.len, got.hi, got.bsy, e.len, e.hi, e.bsy);
    end
  endtask

  task automatic test_async_reset();
    per_t got, e;
    exp_q.push_back(mk(8, 1'b1));
    exp_q.push_back(mk(5, 1'b0));
    measure_period(0, 8'd5, -1, 8'd0, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL odd_load got len=%0d hi=%0d bsy=%0d exp len=%0d hi=%0d bsy=%0d",
               got.len, got.hi, got.bsy, e.len, e.hi, e.bsy);
    end
    measure_period(-1, 8'd0, -1, 8'd0, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL odd_period5 got len=%0d hi=%0d bsy=%0d exp len=%0d hi=%0d bsy=%0d",
               got.len, got.hi, got.bsy, e.len, e.hi, e.bsy);
    end
    checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL arst_pre_high got=%b exp=1", clk_out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL arst_clk_out got=%b exp=0", clk_out); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL arst_running got=%b exp=0", running); end
    checks++; if (active_div !== 8'd25) begin failures++; $display("FAIL arst_active got=%0d exp=25", active_div); end
    checks++; if (busy !== 1'b0 || tick !== 1'b0) begin failures++; $display("FAIL arst_busy_tick got=%b%b exp=00", busy, tick); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL arst_restart got=%b exp=1", running); end
    step();
    checks++; if (tick !== 1'b1) begin failures++; $display("FAIL arst_tick got=%b exp=1", tick); end
    exp_q.push_back(mk(25, 1'b0));
    measure_period(-1, 8'd0, -1, 8'd0, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL arst_period got len=%0d hi=%0d bsy=%0d exp len=%0d hi=%0d bsy=%0d",
               got.len, got.hi, got.bsy, e.len, e.hi, e.bsy);
    end
  endtask

  initial begin
    test_reset();
    test_reload();
    test_back_to_back();
    test_load_at_wrap();
    test_div_err();
    test_park();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clkdiv_prog.md
Name: clkdiv_prog

Overview:
- Runtime-programmable integer clock divider; successor to the fixed divide-by-25 block.
- Produces clk_out = clk / N at 50% duty for both even and odd N. Odd N uses a negedge-retimed half-cycle extension.
- N reloads glitch-free at period boundaries. Also provides enable/park control and a per-period tick in the clk domain.
- Sits between the system clock and slow peripheral clocks/strobes, e.g. a 50 MHz clk with N=25 gives 2 MHz.

Parameters:
- CNT_W, 8, width of divisor and period counter; legal N range is 2..2^CNT_W-1.
- DIV_INIT, 25, divisor active out of reset; must be in 2..2^CNT_W-1.

Ports:
- clk  in  1  source clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run request; low parks the output low at the next period boundary
- div_val  in  CNT_W  requested divisor N
- div_load  in  1  one-clk strobe; captures div_val into the pending register
- div_err  out  1  one-clk pulse, registered; div_load was issued with div_val<2
- busy  out  1  pending divisor not yet applied
- active_div  out  CNT_W  divisor currently in effect
- running  out  1  divider is counting (not parked)
- tick  out  1  one-clk pulse at the start of each output period
- clk_out  out  1  divided clock

Behaviour:
- Reset values:
  - cnt=0, active_div=DIV_INIT, pending=DIV_INIT, busy=0, running=0.
  - tick=0, div_err=0, pos_q=0, neg_q=0, so clk_out=0.
- States:
  - PARK: cnt=0, outputs low.
  - RUN: cnt counts 0..active_div-1, then wraps to 0.
- PARK->RUN: on the first clk with en=1. cnt starts at 0 on that edge and running=1 from that edge.
- RUN->PARK: on the wrap edge (cnt==active_div-1) if en=0. en deasserted mid-period never truncates the current period.
- H = floor(active_div/2).
- pos_q (posedge flop) <= RUN & (cnt < H). clk_out rises 1 clk after cnt==0 is registered.
- tick (registered) <= RUN & (cnt==0). tick is coincident with the clk_out rising edge.
- Even N: clk_out = pos_q. High H clks, low H clks.
- Odd N: neg_q (negedge flop, async reset) <= pos_q. clk_out = pos_q | neg_q. High H+0.5 clks, low H+0.5 clks.
- Divisor reload:
  - div_load with div_val>=2 writes pending and sets busy=1.
  - A later load before application overwrites pending; last value wins.
  - In RUN, pending is applied at the wrap edge: active_div<=pending, busy<=0. The new period uses the new N and H.
  - In PARK, pending is applied on the next clk edge.
- div_load with div_val<2: ignored (pending and busy unchanged), div_err=1 for one clk.
- div_load on the same edge as a wrap: the old pending is applied on this wrap; the new value becomes pending and busy stays 1.
- No runt pulses: clk_out only changes at pos/neg flop edges, and N changes only at boundaries where clk_out is low.
- Async reset mid-period forces all state to reset values immediately; clk_out goes low asynchronously.

Optional Feature:
- Macro: CLKDIV_ODD_EN.
- Defined: negedge flop neg_q is present; odd N gives exact 50% duty as above.
- Undefined:
  - No negedge logic; clk_out = pos_q for all N.
  - Odd N gives H clks high and H+1 clks low.
  - Period, tick and reload behaviour are unchanged.

Test Plan:
- Reset with DIV_INIT=25, en=1 -> tick every 25 clks; clk_out high 12.5 clks (macro on) or 12 clks (macro off); active_div=25.
- div_load with div_val=4 mid-period -> busy=1 until the wrap; the next period is 4 clks with clk_out high 2 / low 2; tick spacing goes 25 then 4.
- Back-to-back div_load 6 then 10 within one period -> only 10 is applied at the next wrap; 6 never appears; busy clears at the wrap.
- div_load with div_val=1, then 0 -> div_err pulses each time; active_div and busy unchanged.
- en=0 at cnt=3 with N=8 -> period completes (cnt reaches 7); running=0 after the wrap; clk_out stays 0 and tick stops; en=1 -> tick appears 1 clk later.
- rst_n asserted while clk_out=1 with N=5 -> clk_out=0 immediately; after release, behaves as after reset with N=DIV_INIT.
